cpu_step_ctrl: RTL and testbench

//   Synchronous counterpart of the clock divider. Runs on the board clock and

---
 rtl/cpu_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator on the board clock: fast/slow free-running strobes, or one
// debounced strobe per button press in single-step mode.
module cpu_step_ctrl #(
    parameter int unsigned FAST_DIV  = 4,
    parameter int unsigned SLOW_DIV  = 33554432,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SW2,
    input  logic        step_mode,
    input  logic        step_btn,
    output logic        cpu_ce,
    output logic [31:0] ce_count,
    output logic        step_busy
);

    localparam int unsigned MaxDiv = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int unsigned DivW   = $clog2(MaxDiv);
    localparam int unsigned DbW    = $clog2(DB_CYCLES);

    localparam logic [DivW-1:0] FastLast = DivW'(FAST_DIV - 1);
    localparam logic [DivW-1:0] SlowLast = DivW'(SLOW_DIV - 1);
    localparam logic [DbW-1:0]  DbLast   = DbW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    // Synchronizer bit order is {step_btn, step_mode, SW2}.
    logic [2:0]      sync_meta_q, sync_s_q;
    logic            sw2_s, step_s, btn_s;

    logic [1:0]      mode, mode_q;
    logic            mode_chg;
    logic [DivW-1:0] div_last;

    state_e          state_q, state_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            ce_q, ce_d;
    logic [31:0]     ce_count_q, ce_count_d;
    logic            busy_q, busy_d;

    assign sw2_s    = sync_s_q[0];
    assign step_s   = sync_s_q[1];
    assign btn_s    = sync_s_q[2];

    assign mode     = {step_s, sw2_s};
    assign mode_chg = (mode != mode_q);
    assign div_last = sw2_s ? SlowLast : FastLast;

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        div_cnt_d  = div_cnt_q;
        ce_d       = 1'b0;
        ce_count_d = ce_count_q + 32'(ce_q);

        if (mode_chg) begin
            // Any mode switch restarts from a clean state, so no short or double strobe.
            div_cnt_d = '0;
            db_cnt_d  = '0;
            state_d   = StIdle;
        end else if (!step_s) begin
            if (div_cnt_q == div_last) begin
                div_cnt_d = '0;
                ce_d      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DivW'(1);
            end
        end else begin
            div_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_d  = StPressWait;
                        db_cnt_d = '0;
                    end
                end
                StPressWait: begin
                    if (!btn_s) begin
                        state_d = StIdle;
                    end else if (db_cnt_q == DbLast) begin
                        state_d = StPressed;
                        ce_d    = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + DbW'(1);
                    end
                end
                StPressed: begin
                    if (!btn_s) begin
                        state_d  = StReleaseWait;
                        db_cnt_d = '0;
                    end
                end
                StReleaseWait: begin
                    // A bounce back to high returns to the held state without a new strobe.
                    if (btn_s) begin
                        state_d = StPressed;
                    end else if (db_cnt_q == DbLast) begin
                        state_d = StIdle;
                    end else begin
                        db_cnt_d = db_cnt_q + DbW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_s_q    <= '0;
            mode_q      <= '0;
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            div_cnt_q   <= '0;
            ce_q        <= 1'b0;
            ce_count_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            sync_meta_q <= {step_btn, step_mode, SW2};
            sync_s_q    <= sync_meta_q;
            mode_q      <= mode;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ce_q        <= ce_d;
            ce_count_q  <= ce_count_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ce    = ce_q;
    assign ce_count  = ce_count_q;
    assign step_busy = busy_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: run-length reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_cpu_step_ctrl;

    localparam int unsigned FastDiv  = 4;
    localparam int unsigned SlowDiv  = 16;
    localparam int unsigned DbCycles = 8;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        SW2       = 1'b0;
    logic        step_mode = 1'b0;
    logic        step_btn  = 1'b0;
    logic        cpu_ce;
    logic [31:0] ce_count;
    logic        step_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;
    int strobes = 0;
    int hold    = 0;

    // Reference model state: two-sample input delay, edges since last restart, and the
    // length of the current run of samples that would flip the debounced button level.
    bit          sw_m, sw_s, sm_m, sm_s, bt_m, bt_s;
    bit [1:0]    m_mode_prev, m_mode;
    int          m_k, m_run;
    bit          m_latched, m_ce, m_busy, m_fire;
    logic [31:0] m_cnt = '0;

    cpu_step_ctrl #(
        .FAST_DIV (FastDiv),
        .SLOW_DIV (SlowDiv),
        .DB_CYCLES(DbCycles)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SW2      (SW2),
        .step_mode(step_mode),
        .step_btn (step_btn),
        .cpu_ce   (cpu_ce),
        .ce_count (ce_count),
        .step_busy(step_busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (cpu_ce === 1'b1) strobes++;
    endtask

    task automatic wait_ce(input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (cpu_ce === 1'b1) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic drive_btn(input logic level, input int cycles);
        step_btn = level;
        repeat (cycles) tick();
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            {sw_m, sw_s, sm_m, sm_s, bt_m, bt_s} = '0;
            m_mode_prev = '0;
            m_k         = 0;
            m_run       = 0;
            m_latched   = 1'b0;
            m_ce        = 1'b0;
            m_busy      = 1'b0;
            m_cnt       = '0;
        end else begin
            m_cnt  = m_cnt + 32'(m_ce);
            m_mode = {sm_s, sw_s};
            m_fire = 1'b0;
            if (m_mode != m_mode_prev) begin
                m_k       = 0;
                m_run     = 0;
                m_latched = 1'b0;
            end else if (!sm_s) begin
                m_k++;
                if (m_k % int'(sw_s ? SlowDiv : FastDiv) == 0) m_fire = 1'b1;
            end else if (!m_latched) begin
                m_run = bt_s ? m_run + 1 : 0;
                if (m_run == int'(DbCycles) + 1) begin
                    m_fire    = 1'b1;
                    m_latched = 1'b1;
                    m_run     = 0;
                end
            end else begin
                m_run = bt_s ? 0 : m_run + 1;
                if (m_run == int'(DbCycles) + 1) begin
                    m_latched = 1'b0;
                    m_run     = 0;
                end
            end
            m_mode_prev = m_mode;
            m_ce        = m_fire;
            m_busy      = m_latched || (m_run != 0);
            sw_s = sw_m;  sw_m = SW2;
            sm_s = sm_m;  sm_m = step_mode;
            bt_s = bt_m;  bt_m = step_btn;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("model_cpu_ce", 32'(cpu_ce), 32'(m_ce));
            chk("model_ce_count", ce_count, m_cnt);
            chk("model_step_busy", 32'(step_busy), 32'(m_busy));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_ce_count", ce_count, 32'd0);
        chk("reset_busy", 32'(step_busy), 32'd0);
        rst = 1'b0;

        // Fast run from reset: strobes after edges 4, 8, 12.
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("t1_ce", 32'(cpu_ce), 32'(k % 4 == 0));
        end
        chk("t1_count", ce_count, 32'd3);

        // Slow run: once settled, four strobes in every 64 edges.
        SW2 = 1'b1;
        repeat (4) tick();
        wait_ce(40, "t2_first_slow");
        strobes = 0;
        repeat (64) tick();
        chk("t2_strobes", 32'(strobes), 32'd4);

        // Single clean press held for 20 cycles.
        SW2       = 1'b0;
        step_mode = 1'b1;
        step_btn  = 1'b0;
        repeat (10) tick();
        strobes  = 0;
        step_btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("t3_ce", 32'(cpu_ce), 32'(k == 11));
            chk("t3_busy", 32'(step_busy), 32'(k >= 3 && k <= 30));
            if (k == 20) step_btn = 1'b0;
        end
        chk("t3_strobes", 32'(strobes), 32'd1);

        // Bouncy press and bouncy release.
        strobes = 0;
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 2);
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 1);
        drive_btn(1'b1, 20);
        chk("t4_press_strobes", 32'(strobes), 32'd1);
        drive_btn(1'b0, 2);
        drive_btn(1'b1, 2);
        drive_btn(1'b0, 20);
        chk("t4_total_strobes", 32'(strobes), 32'd1);
        chk("t4_idle", 32'(step_busy), 32'd0);

        // Reset mid-debounce, then mid-slow-count.
        step_btn = 1'b1;
        repeat (6) tick();
        chk("t5_busy_before", 32'(step_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5a_ce", 32'(cpu_ce), 32'd0);
        chk("t5a_count", ce_count, 32'd0);
        chk("t5a_busy", 32'(step_busy), 32'd0);
        rst       = 1'b0;
        step_btn  = 1'b0;
        step_mode = 1'b0;
        SW2       = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("t5b_ce", 32'(cpu_ce), 32'd0);
        chk("t5b_count", ce_count, 32'd0);
        chk("t5b_busy", 32'(step_busy), 32'd0);
        rst = 1'b0;

        // Counter wrap from all-ones.
        SW2 = 1'b0;
        repeat (8) tick();
        wait_ce(10, "t6_sync");
        tick();
        #1;
        force dut.ce_count_d = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.ce_count_d;
        chk("t6_preload", ce_count, 32'hFFFF_FFFF);
        wait_ce(10, "t6_strobe");
        tick();
        chk("t6_wrap", ce_count, 32'd0);

        // Randomized phase.
        step_mode = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 99) < 2) SW2 = ~SW2;
            if ($urandom_range(0, 99) < 1) step_mode = ~step_mode;
            if (hold == 0) begin
                step_btn = ~step_btn;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(5, 25));
            end else begin
                hold--;
            end
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
